// File: rtl/sfifo_flags.sv
// Single-clock synchronous FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags, synchronous flush and optional first-word-fall-through.
module sfifo_flags #(
  parameter int DEPTH    = 16,
  parameter int DEPTH_l  = $clog2(DEPTH),
  parameter int WIDTH    = 8,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr,
  input  logic [WIDTH-1:0]   din,
  input  logic               rd,
  output logic [WIDTH-1:0]   dout,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic [DEPTH_l:0]   count,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [DEPTH_l:0] DEPTH_C = DEPTH[DEPTH_l:0];
  localparam logic [DEPTH_l:0] AF_C    = AF_LEVEL[DEPTH_l:0];
  localparam logic [DEPTH_l:0] AE_C    = AE_LEVEL[DEPTH_l:0];

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
      !(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_params
    $error("sfifo_flags: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
  end

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [DEPTH_l-1:0] wptr_reg, rptr_reg;
  logic [DEPTH_l:0]   count_reg, count_next;
  logic               full_reg, empty_reg, af_reg, ae_reg;
  logic               overflow_reg, underflow_reg;
  logic               wr_ok, rd_ok;

  // Acceptance looks only at registered flags: no pass-through on full or empty.
  assign wr_ok = wr && !full_reg;
  assign rd_ok = rd && !empty_reg;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      af_reg        <= 1'b0;
      ae_reg        <= 1'b1;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wptr_reg <= wptr_reg + 1'b1;
      if (rd_ok) rptr_reg <= rptr_reg + 1'b1;
      count_reg <= count_next;
      full_reg  <= (count_next == DEPTH_C);
      empty_reg <= (count_next == '0);
      af_reg    <= (count_next >= AF_C);
      ae_reg    <= (count_next <= AE_C);
      if (wr && full_reg)  overflow_reg  <= 1'b1;
      if (rd && empty_reg) underflow_reg <= 1'b1;
    end
  end

  // Storage has no reset so it can map onto RAM resources.
  always_ff @(posedge clock) begin
    if (!reset && !clear && wr_ok) mem[wptr_reg] <= din;
  end

  if (FWFT) begin : g_fwft
    assign dout = mem[rptr_reg];
  end else begin : g_std
    logic [WIDTH-1:0] dout_reg;
    // Flush leaves the last read word on the output; only reset zeroes it.
    always_ff @(posedge clock) begin
      if (reset)                dout_reg <= '0;
      else if (!clear && rd_ok) dout_reg <= mem[rptr_reg];
    end
    assign dout = dout_reg;
  end

  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: doc/sfifo_flags.md
Name: sfifo_flags

Overview:
Single-clock, parametrised synchronous FIFO. It is the same-domain successor to the team's dual-clock FIFO and keeps the same wr/din/rd/dout/full/empty handshake. It adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode. It is used for buffering between pipeline stages inside one clock domain.

Parameters:
DEPTH, 16, number of entries; power of two, >= 2
DEPTH_l, $clog2(DEPTH), pointer width
WIDTH, 8, data width in bits
AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = standard read (registered dout); 1 = first-word-fall-through

Ports:
clock  input  1  single clock; all logic on rising edge
reset  input  1  synchronous reset, active-high
clear  input  1  synchronous flush, active-high
wr  input  1  write request
din  input  WIDTH  write data
rd  input  1  read request
dout  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  DEPTH_l+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: wr attempted while full
underflow  output  1  sticky: rd attempted while empty

Behaviour:
- Reset (reset high at a clock edge): pointers=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, dout=0. Memory contents are not cleared. Reset overrides all other inputs, including mid-burst.
- clear: same effect as reset on pointers, count, flags and sticky bits; dout holds its value. Takes precedence over wr/rd in the same cycle.
- Write accepted iff wr && !full. Data goes to mem[wptr], and wptr increments modulo DEPTH (natural wrap, DEPTH_l bits).
- Read accepted iff rd && !empty. rptr increments modulo DEPTH.
- Full or empty decisions use registered count only. There is no pass-through: wr to a full FIFO is rejected even if rd is accepted in the same cycle. rd on an empty FIFO is rejected even if wr is accepted.
- count: +1 on write only, -1 on read only, unchanged when both are accepted or neither is. full, empty, almost_* are registered versions of the next count, so they are valid in the same cycle as count.
- Flag latency: one write into an empty FIFO gives empty=0 on the next cycle. One read from a full FIFO gives full=0 on the next cycle.
- FWFT=0: on an accepted read, dout <= mem[rptr] at that edge, so data is visible one cycle after rd. dout holds when there is no accepted read.
- FWFT=1: dout always presents mem[rptr] (the head). It is valid whenever empty=0. An accepted rd advances to the next entry, visible the following cycle. Contents of dout are don't-care while empty=1.
- overflow sets on wr && full. underflow sets on rd && empty. Both stay set until reset or clear. A rejected access changes nothing else.
- Threshold parameters are static. The block requires AE_LEVEL < AF_LEVEL <= DEPTH; an elaboration check errors otherwise.

Test Plan:
(All with DEPTH=16, WIDTH=8, AF_LEVEL=12, AE_LEVEL=2.)
1. Reset, then idle: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, dout=0.
2. Write 0x00..0x0F on 16 consecutive cycles:
   - almost_empty drops after the 3rd write (count=3).
   - almost_full rises when count=12.
   - full=1 when count=16.
   - A 17th write (0xAA) is rejected: overflow=1, count stays 16.
   - Reading all entries returns 0x00..0x0F in order.
3. With the FIFO holding 5 entries, assert wr and rd together for 20 cycles: count stays 5, and data order is preserved across pointer wrap-around.
4. rd on an empty FIFO: underflow=1, count=0, dout unchanged. Then wr and rd together on the empty FIFO: the write is accepted, count=1, and rd has no effect.
5. FWFT=1: write 0x5A into an empty FIFO. The next cycle shows empty=0 and dout=0x5A before any rd. rd then gives empty=1 the next cycle. FWFT=0: 0x5A appears on dout one cycle after rd.
6. With 9 entries and overflow=1, assert clear together with wr=1: count=0, empty=1, overflow=0, and the write is discarded. A reset mid-burst likewise returns every output to its reset value.
